alu_vector_checker: RTL and testbench

ALU_VECTOR_CHECKER -- requirements
Module: alu_vector_checker

---
 rtl/alu_vector_checker.sv | 161 ++++++++++++++++
 tb/tb_alu_vector_checker.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_vector_checker.sv
// alu_vector_checker: replays stored ALU vectors against an external ALU and tallies mismatches
module alu_vector_checker #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    parameter int SETTLE = 1,
    parameter int HALT_ON_ERR = 0,
    localparam int AW = $clog2(DEPTH),
    localparam int VW = 3 * WIDTH + 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [AW-1:0]    vec_addr,
    input  logic [VW-1:0]    vec_rdata,
    output logic [WIDTH-1:0] dut_a,
    output logic [WIDTH-1:0] dut_b,
    output logic [2:0]       dut_f,
    input  logic [WIDTH-1:0] dut_y,
    input  logic             dut_n,
    input  logic             dut_z,
    input  logic             dut_c,
    input  logic             dut_v,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [AW:0]      vec_count,
    output logic [AW:0]      err_count,
    output logic             first_fail_valid,
    output logic [AW-1:0]    first_fail_idx
);
    localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, APPLY, CHECK, DONE} state_t;

    state_t state_q, state_d;
    logic [AW-1:0] idx_q, idx_d, ffi_q, ffi_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, exp_y_q, exp_y_d;
    logic [2:0] f_q, f_d;
    logic [3:0] exp_nzcv_q, exp_nzcv_d, mask_q, mask_d;
    logic [AW:0] vc_q, vc_d, ec_q, ec_d;
    logic ffv_q, ffv_d;

    logic rd_valid;
    logic [2:0] rd_f;
    logic [WIDTH-1:0] rd_a, rd_b, rd_y;
    logic [3:0] rd_nzcv, rd_mask;
    logic launch, first_apply, settled, last, mismatch, stop;

    assign {rd_valid, rd_f, rd_a, rd_b, rd_y, rd_nzcv, rd_mask} = vec_rdata;
    assign launch = start && (state_q == IDLE || state_q == DONE);
    assign first_apply = state_q == APPLY && cnt_q == '0;
    assign settled = cnt_q == SW'(SETTLE - 1);
    assign last = idx_q == AW'(DEPTH - 1);
    // A cleared mask bit excludes that flag from the comparison
    assign mismatch = (dut_y != exp_y_q) || ((({dut_n, dut_z, dut_c, dut_v} ^ exp_nzcv_q) & mask_q) != 4'h0);
    assign stop = last || (mismatch && HALT_ON_ERR != 0);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = start ? FETCH : state_q;
            FETCH:      state_d = APPLY;
            APPLY:      state_d = first_apply && !rd_valid ? DONE : settled ? CHECK : APPLY;
            CHECK:      state_d = stop ? DONE : FETCH;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = state_q inside {FETCH, APPLY, CHECK};
        done = state_q == DONE;
        pass = done && ec_q == '0;
    end

    always_comb begin
        idx_d = idx_q;
        cnt_d = cnt_q;
        a_d = a_q;
        b_d = b_q;
        f_d = f_q;
        exp_y_d = exp_y_q;
        exp_nzcv_d = exp_nzcv_q;
        mask_d = mask_q;
        vc_d = vc_q;
        ec_d = ec_q;
        ffv_d = ffv_q;
        ffi_d = ffi_q;
        if (launch) begin
            idx_d = '0;
            vc_d = '0;
            ec_d = '0;
            ffv_d = 1'b0;
            ffi_d = '0;
        end
        if (state_q == FETCH) cnt_d = '0;
        if (state_q == APPLY) cnt_d = cnt_q + 1'b1;
        // Read data arrives during the first APPLY cycle; operands then hold for SETTLE cycles
        if (first_apply && rd_valid) begin
            a_d = rd_a;
            b_d = rd_b;
            f_d = rd_f;
            exp_y_d = rd_y;
            exp_nzcv_d = rd_nzcv;
            mask_d = rd_mask;
        end
        if (state_q == CHECK) begin
            vc_d = vc_q + 1'b1;
            if (mismatch) ec_d = ec_q + 1'b1;
            if (mismatch && !ffv_q) begin
                ffv_d = 1'b1;
                ffi_d = idx_q;
            end
            if (!stop) idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= '0;
            cnt_q <= '0;
            a_q <= '0;
            b_q <= '0;
            f_q <= '0;
            exp_y_q <= '0;
            exp_nzcv_q <= '0;
            mask_q <= '0;
            vc_q <= '0;
            ec_q <= '0;
            ffv_q <= 1'b0;
            ffi_q <= '0;
        end else begin
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            a_q <= a_d;
            b_q <= b_d;
            f_q <= f_d;
            exp_y_q <= exp_y_d;
            exp_nzcv_q <= exp_nzcv_d;
            mask_q <= mask_d;
            vc_q <= vc_d;
            ec_q <= ec_d;
            ffv_q <= ffv_d;
            ffi_q <= ffi_d;
        end
    end

    assign vec_addr = idx_q;
    assign dut_a = a_q;
    assign dut_b = b_q;
    assign dut_f = f_q;
    assign vec_count = vc_q;
    assign err_count = ec_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_idx = ffi_q;
endmodule

// File: tb/tb_alu_vector_checker.sv
// tb_alu_vector_checker: directed vector runs checked cycle by cycle against a timeline model
module tb_alu_vector_checker;
    localparam int W = 32;
    localparam int D = 8;
    localparam int AW = 3;
    localparam int VW = 3 * W + 12;
    localparam logic [2:0] F_ADD = 3'd0, F_SUB = 3'd1, F_AND = 3'd2, F_OR = 3'd3, F_XOR = 3'd4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start [2];
    logic [AW-1:0] vec_addr [2];
    logic [VW-1:0] rdata [2];
    logic [W-1:0] dut_a [2], dut_b [2], dut_y [2];
    logic [2:0] dut_f [2];
    logic dut_n [2], dut_z [2], dut_c [2], dut_v [2];
    logic busy [2], done [2], pass [2], ffv [2];
    logic [AW:0] vec_count [2], err_count [2];
    logic [AW-1:0] ffi [2];
    logic [VW-1:0] mem [2][D];
    logic [VW-1:0] tab_add [D], tab_mix [D];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    // Reference ALU: drives the DUT's ALU inputs and also scores the vectors in the model
    function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        logic [32:0] s;
        logic [31:0] y;
        logic c, v;
        s = '0;
        y = '0;
        c = 1'b0;
        v = 1'b0;
        case (f)
            F_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                y = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (y[31] != a[31]);
            end
            F_SUB: begin
                y = a - b;
                c = a >= b;
                v = (a[31] != b[31]) && (y[31] != a[31]);
            end
            F_AND: y = a & b;
            F_OR:  y = a | b;
            F_XOR: y = a ^ b;
            default: y = '0;
        endcase
        return {y, y[31], y == 32'h0, c, v};
    endfunction

    function automatic logic [VW-1:0] vec(input logic vld, input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] y, input logic [3:0] nzcv,
                                          input logic [3:0] mask);
        return {vld, f, a, b, y, nzcv, mask};
    endfunction

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : gi
        alu_vector_checker #(.WIDTH(W), .DEPTH(D), .SETTLE(1), .HALT_ON_ERR(g)) dut (
            .clk(clk), .reset(reset), .start(start[g]), .vec_addr(vec_addr[g]), .vec_rdata(rdata[g]),
            .dut_a(dut_a[g]), .dut_b(dut_b[g]), .dut_f(dut_f[g]), .dut_y(dut_y[g]),
            .dut_n(dut_n[g]), .dut_z(dut_z[g]), .dut_c(dut_c[g]), .dut_v(dut_v[g]),
            .busy(busy[g]), .done(done[g]), .pass(pass[g]), .vec_count(vec_count[g]),
            .err_count(err_count[g]), .first_fail_valid(ffv[g]), .first_fail_idx(ffi[g])
        );
        always @(posedge clk) rdata[g] <= mem[g][vec_addr[g]];
        assign {dut_y[g], dut_n[g], dut_z[g], dut_c[g], dut_v[g]} = alu_ref(dut_a[g], dut_b[g], dut_f[g]);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Run expectations derived from memory contents: each vector takes 3 cycles,
    // an invalid entry ends the run after its FETCH and APPLY
    int m_n, m_end, m_ff;
    int m_ep [D+1];
    logic [W-1:0] m_a [D], m_b [D];
    logic [2:0] m_f [D];
    int sel = 0;
    int c0 = 0;
    bit mon_en = 1'b0;
    int max_addr = 0;

    task automatic build(input int s);
        logic [VW-1:0] v;
        logic [35:0] r;
        bit mis;
        m_n = 0;
        m_ff = 0;
        m_end = 3 * D + 1;
        m_ep[0] = 0;
        for (int k = 0; k < D; k++) begin
            v = mem[s][k];
            if (!v[VW-1]) begin
                m_end = 3 * k + 3;
                break;
            end
            m_f[k] = v[106:104];
            m_a[k] = v[103:72];
            m_b[k] = v[71:40];
            r = alu_ref(m_a[k], m_b[k], m_f[k]);
            mis = (r[35:4] != v[39:8]) || (((r[3:0] ^ v[7:4]) & v[3:0]) != 4'h0);
            m_ep[k+1] = m_ep[k] + int'(mis);
            if (mis && m_ep[k] == 0) m_ff = k;
            m_n = k + 1;
            if (mis && s == 1) begin
                m_end = 3 * k + 4;
                break;
            end
        end
    endtask

    always @(negedge clk) begin : mon
        int d, k, ph;
        if (mon_en) begin
            d = cyc - c0;
            if (d >= 1 && d >= m_end) begin
                chk("done_lvl", done[sel], 1);
                chk("done_busy", busy[sel], 0);
                chk("done_pass", pass[sel], m_ep[m_n] == 0);
                chk("done_vc", vec_count[sel], m_n);
                chk("done_ec", err_count[sel], m_ep[m_n]);
                chk("done_ffv", ffv[sel], m_ep[m_n] != 0);
                if (m_ep[m_n] != 0) chk("done_ffi", ffi[sel], m_ff);
                if (m_n > 0) begin
                    chk("hold_a", dut_a[sel], m_a[m_n-1]);
                    chk("hold_b", dut_b[sel], m_b[m_n-1]);
                    chk("hold_f", dut_f[sel], m_f[m_n-1]);
                end
            end else if (d >= 1) begin
                k = (d - 1) / 3;
                ph = (d - 1) % 3;
                chk("run_busy", busy[sel], 1);
                chk("run_done", done[sel], 0);
                chk("run_pass", pass[sel], 0);
                chk("run_vc", vec_count[sel], k);
                chk("run_ec", err_count[sel], m_ep[k]);
                chk("run_ffv", ffv[sel], m_ep[k] != 0);
                if (m_ep[k] != 0) chk("run_ffi", ffi[sel], m_ff);
                if (ph == 0) chk("fetch_addr", vec_addr[sel], k);
                if (ph == 2) begin
                    chk("chk_a", dut_a[sel], m_a[k]);
                    chk("chk_b", dut_b[sel], m_b[k]);
                    chk("chk_f", dut_f[sel], m_f[k]);
                end
            end
        end
    end

    task automatic run(input int s, input int restart_d, input int abort_d, output int end_d);
        int d;
        build(s);
        @(negedge clk);
        c0 = cyc;
        sel = s;
        start[s] = 1'b1;
        mon_en = 1'b1;
        end_d = -1;
        max_addr = 0;
        for (int i = 0; i < 200 && end_d < 0; i++) begin
            @(negedge clk);
            d = cyc - c0;
            start[s] = d == restart_d;
            if (busy[s] && int'(vec_addr[s]) > max_addr) max_addr = int'(vec_addr[s]);
            if (d == abort_d) begin
                mon_en = 1'b0;
                reset = 1'b1;
                start[s] = 1'b0;
                @(negedge clk);
                return;
            end
            if (done[s]) end_d = d;
        end
        chk("run_finished", done[s], 1);
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        start[s] = 1'b0;
    endtask

    task automatic zeros(input int s);
        chk("z_addr", vec_addr[s], 0);
        chk("z_a", dut_a[s], 0);
        chk("z_b", dut_b[s], 0);
        chk("z_f", dut_f[s], 0);
        chk("z_busy", busy[s], 0);
        chk("z_done", done[s], 0);
        chk("z_pass", pass[s], 0);
        chk("z_vc", vec_count[s], 0);
        chk("z_ec", err_count[s], 0);
        chk("z_ffv", ffv[s], 0);
        chk("z_ffi", ffi[s], 0);
    endtask

    task automatic load(input int s, input bit mix);
        for (int k = 0; k < D; k++) mem[s][k] = mix ? tab_mix[k] : tab_add[k];
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e;
        start[0] = 1'b0;
        start[1] = 1'b0;
        tab_add[0] = vec(1, F_ADD, 32'h1, 32'h2, 32'h3, 4'b0000, 4'hF);
        tab_add[1] = vec(1, F_ADD, 32'hFFFFFFFF, 32'h1, 32'h0, 4'b0110, 4'hF);
        tab_add[2] = vec(1, F_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b1001, 4'hF);
        tab_add[3] = vec(1, F_ADD, 32'h2, 32'h2, 32'h4, 4'b0000, 4'hF);
        tab_add[4] = vec(1, F_ADD, 32'h80000000, 32'h80000000, 32'h0, 4'b0111, 4'hF);
        tab_add[5] = vec(1, F_ADD, 32'h12345678, 32'h11111111, 32'h23456789, 4'b0000, 4'hF);
        tab_add[6] = vec(1, F_ADD, 32'hF0000000, 32'h10000000, 32'h0, 4'b0110, 4'hF);
        tab_add[7] = vec(1, F_ADD, 32'h40000000, 32'h40000000, 32'h80000000, 4'b1001, 4'hF);
        tab_mix[0] = vec(1, F_SUB, 32'h5, 32'h3, 32'h2, 4'b0010, 4'hF);
        tab_mix[1] = vec(1, F_SUB, 32'h3, 32'h5, 32'hFFFFFFFE, 4'b1000, 4'hF);
        tab_mix[2] = vec(1, F_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000, 4'hF);
        tab_mix[3] = vec(1, F_OR, 32'h0, 32'h0, 32'h0, 4'b0100, 4'hF);
        tab_mix[4] = vec(1, F_XOR, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 4'b1000, 4'hF);
        tab_mix[5] = vec(1, F_SUB, 32'h80000000, 32'h1, 32'h7FFFFFFF, 4'b0011, 4'hF);
        tab_mix[6] = vec(1, F_XOR, 32'h1234, 32'h1234, 32'h0, 4'b0100, 4'hF);
        tab_mix[7] = vec(1, F_AND, 32'hFFFFFFFF, 32'h0, 32'h0, 4'b0100, 4'hF);
        load(0, 0);
        load(1, 0);
        repeat (3) @(negedge clk);
        zeros(0);
        zeros(1);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        zeros(0);
        chk("pin_ovf", alu_ref(32'h7FFFFFFF, 32'h1, F_ADD), {32'h80000000, 4'b1001});
        chk("pin_carry", alu_ref(32'hFFFFFFFF, 32'h1, F_ADD), {32'h0, 4'b0110});
        chk("pin_borrow", alu_ref(32'h3, 32'h5, F_SUB), {32'hFFFFFFFE, 4'b1000});

        run(0, 5, 0, e);
        chk("add_end", e, 25);
        chk("add_vc", vec_count[0], 8);
        chk("add_ec", err_count[0], 0);
        chk("add_pass", pass[0], 1);

        mem[0][3] = vec(1, F_ADD, 32'h2, 32'h2, 32'h5, 4'b0000, 4'hF);
        run(0, 0, 0, e);
        chk("y3_vc", vec_count[0], 8);
        chk("y3_ec", err_count[0], 1);
        chk("y3_ffi", ffi[0], 3);
        chk("y3_pass", pass[0], 0);

        load(0, 0);
        mem[0][2] = vec(1, F_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b1000, 4'h1);
        run(0, 0, 0, e);
        chk("v_mask1_ec", err_count[0], 1);
        chk("v_mask1_ffi", ffi[0], 2);
        mem[0][2] = vec(1, F_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b1000, 4'h0);
        run(0, 0, 0, e);
        chk("v_mask0_ec", err_count[0], 0);
        chk("v_mask0_pass", pass[0], 1);

        load(0, 0);
        mem[0][4][VW-1] = 1'b0;
        run(0, 0, 0, e);
        chk("inv4_end", e, 15);
        chk("inv4_vc", vec_count[0], 4);
        chk("inv4_maxaddr", max_addr, 4);

        for (int k = 0; k < D; k++) mem[0][k][VW-1] = 1'b0;
        run(0, 0, 0, e);
        chk("empty_end", e, 3);
        chk("empty_vc", vec_count[0], 0);
        chk("empty_pass", pass[0], 1);

        load(0, 1);
        run(0, 0, 0, e);
        chk("mix_end", e, 25);
        chk("mix_pass", pass[0], 1);

        mem[1][1] = vec(1, F_ADD, 32'hFFFFFFFF, 32'h1, 32'h1, 4'b0110, 4'hF);
        mem[1][5] = vec(1, F_ADD, 32'h12345678, 32'h11111111, 32'h0, 4'b0000, 4'hF);
        run(1, 0, 0, e);
        chk("halt_end", e, 7);
        chk("halt_vc", vec_count[1], 2);
        chk("halt_ec", err_count[1], 1);
        chk("halt_ffi", ffi[1], 1);
        chk("halt_pass", pass[1], 0);

        load(0, 0);
        run(0, 0, 14, e);
        zeros(0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        zeros(0);
        run(0, 0, 0, e);
        chk("rerun_end", e, 25);
        chk("rerun_vc", vec_count[0], 8);
        chk("rerun_pass", pass[0], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
